// File: rtl/debug_uart_dumper.sv
// debug_uart_dumper
//   Snapshots the core debug port (PC, data address, instruction, then every
//   register through debug_reg_addr) and streams it out as 8N1 UART bytes,
//   LSB first, each 32-bit word MSB byte first, preceded by a 0xA5 header.
//   Register contents are only meaningful while the core clock is stopped.
//
//   Build option: define DEBUG_DUMP_CHECKSUM_EN to append one XOR checksum
//   byte covering every frame byte except the 0xA5 header.
//
// Ports
//   clk, aresetn           clock, async active-low reset
//   trigger                1-cycle start pulse, ignored unless idle
//   dbg_pc/addr/inst/reg   core debug words (dbg_reg selected by debug_reg_addr)
//   debug_reg_addr         register select driven to the core
//   tx                     UART line, idle high
//   busy                   frame in progress
//   done                   1-cycle pulse after the last stop bit
module debug_uart_dumper #(
  parameter int CLK_DIV       = 868,
  parameter int NUM_REGS      = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        trigger,
  input  logic [31:0] dbg_pc,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_inst,
  input  logic [31:0] dbg_reg,
  output logic [4:0]  debug_reg_addr,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam logic [15:0] DIV_LAST    = 16'(CLK_DIV - 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  // Word index: 0 header, 1 pc, 2 addr, 3 inst, 4.. registers, then checksum.
  localparam logic [5:0]  LAST_REG    = 6'(3 + NUM_REGS);

  typedef enum logic [1:0] {IDLE, SEND, SETTLE, FIN} state_t;

  state_t      state;
  logic [15:0] div_cnt;
  logic [3:0]  bit_cnt;     // 0 start, 1..8 data, 9 stop
  logic [1:0]  bidx;        // byte within word; header is loaded as the last byte
  logic [5:0]  wsel;
  logic [7:0]  settle_cnt;
  logic [31:0] pc_q, addr_q, inst_q;
  logic [31:0] word_q;      // current byte always sits in [31:24]
  logic [7:0]  cur_byte;
  logic [31:0] fixed_word;

  assign cur_byte = word_q[31:24];

  always_comb begin
    fixed_word = inst_q;
    if (wsel == 6'd0)      fixed_word = pc_q;
    else if (wsel == 6'd1) fixed_word = addr_q;
  end

`ifdef DEBUG_DUMP_CHECKSUM_EN
  logic [7:0] csum;
  logic [7:0] csum_nxt;
  assign csum_nxt = (wsel == 6'd0) ? csum : (csum ^ cur_byte);
`endif

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= IDLE;
      tx             <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      debug_reg_addr <= '0;
      div_cnt        <= '0;
      bit_cnt        <= '0;
      bidx           <= '0;
      wsel           <= '0;
      settle_cnt     <= '0;
      pc_q           <= '0;
      addr_q         <= '0;
      inst_q         <= '0;
      word_q         <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
      csum           <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            pc_q    <= dbg_pc;
            addr_q  <= dbg_addr;
            inst_q  <= dbg_inst;
            word_q  <= {8'hA5, 24'h0};
            wsel    <= '0;
            bidx    <= 2'd3;
            busy    <= 1'b1;
            tx      <= 1'b0;          // start bit begins next cycle
            bit_cnt <= '0;
            div_cnt <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
            csum    <= '0;
`endif
            state   <= SEND;
          end
        end

        SEND: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 16'd1;
          end else begin
            div_cnt <= '0;
            if (bit_cnt != 4'd9) begin
              bit_cnt <= bit_cnt + 4'd1;
              tx      <= (bit_cnt == 4'd8) ? 1'b1 : cur_byte[bit_cnt[2:0]];
            end else begin
              // End of stop bit: pick the next byte with no idle gap,
              // or hand off to SETTLE / FIN.
              bit_cnt <= '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
              csum    <= csum_nxt;
`endif
              if (bidx != 2'd3) begin
                bidx   <= bidx + 2'd1;
                word_q <= {word_q[23:0], 8'h00};
                tx     <= 1'b0;
              end else if (wsel < 6'd3) begin
                wsel   <= wsel + 6'd1;
                bidx   <= '0;
                word_q <= fixed_word;
                tx     <= 1'b0;
              end else if (wsel < LAST_REG) begin
                debug_reg_addr <= 5'(wsel - 6'd3);
                settle_cnt     <= '0;
                tx             <= 1'b1;
                state          <= SETTLE;
`ifdef DEBUG_DUMP_CHECKSUM_EN
              end else if (wsel == LAST_REG) begin
                wsel   <= wsel + 6'd1;
                bidx   <= 2'd3;
                word_q <= {csum_nxt, 24'h0};
                tx     <= 1'b0;
`endif
              end else begin
                done           <= 1'b1;
                busy           <= 1'b0;
                debug_reg_addr <= '0;
                tx             <= 1'b1;
                state          <= FIN;
              end
            end
          end
        end

        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            word_q  <= dbg_reg;
            wsel    <= wsel + 6'd1;
            bidx    <= '0;
            tx      <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
            state   <= SEND;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end

        FIN: state <= IDLE;   // a trigger seen here is dropped

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_uart_dumper.sv
// Bench for debug_uart_dumper: UART monitor decodes tx, a queue-based model
// builds the expected frame from the latched words and the register file.
module tb_debug_uart_dumper;

  localparam int CLK_DIV = 4;
  localparam int SETTLE  = 2;
  localparam int NR      = 32;
`ifdef DEBUG_DUMP_CHECKSUM_EN
  localparam int NB = 14 + 4 * NR;
`else
  localparam int NB = 13 + 4 * NR;
`endif
  localparam int BUSY_EXP = NB * 10 * CLK_DIV + NR * SETTLE;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        trigger = 1'b0;
  logic [31:0] dbg_pc = '0, dbg_addr = '0, dbg_inst = '0;
  logic [31:0] dbg_reg;
  logic [4:0]  debug_reg_addr;
  logic        tx, busy, done;

  logic [31:0] regfile [32];
  bit          rand_mode = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [4:0] addr_log[$];
  logic [4:0] prev_addr = '0;
  int   done_cnt = 0;
  int   busy_cnt = 0;
  int   rx_count = 0;
  logic [7:0] last_rx = '0;

  always #5 clk = ~clk;

  always_comb dbg_reg = rand_mode ? regfile[debug_reg_addr]
                                  : {4{3'b000, debug_reg_addr}};

  debug_uart_dumper #(.CLK_DIV(CLK_DIV), .NUM_REGS(NR), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .aresetn(aresetn), .trigger(trigger),
    .dbg_pc(dbg_pc), .dbg_addr(dbg_addr), .dbg_inst(dbg_inst), .dbg_reg(dbg_reg),
    .debug_reg_addr(debug_reg_addr), .tx(tx), .busy(busy), .done(done));

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (debug_reg_addr !== prev_addr) begin
      addr_log.push_back(debug_reg_addr);
      prev_addr = debug_reg_addr;
    end
  end

  function automatic logic [31:0] reg_val(input int i);
    logic [4:0] a;
    a = 5'(i);
    return rand_mode ? regfile[i] : {4{3'b000, a}};
  endfunction

  // Frame model: header, then pc/addr/inst/registers MSB byte first, optional XOR.
  task automatic build_exp(input logic [31:0] pc, input logic [31:0] ad, input logic [31:0] in);
    logic [31:0] words[$];
    logic [7:0]  cs;
    logic [7:0]  by;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    cs = 8'h00;
    words.push_back(pc); words.push_back(ad); words.push_back(in);
    for (int i = 0; i < NR; i++) words.push_back(reg_val(i));
    foreach (words[w])
      for (int b = 3; b >= 0; b--) begin
        by = 8'(words[w] >> (8 * b));
        exp_q.push_back(by);
        cs ^= by;
      end
`ifdef DEBUG_DUMP_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  // Decodes one byte; every bit must hold its level for CLK_DIV samples.
  task automatic capture_byte(output logic [7:0] b, output bit ok);
    int n;
    ok = 1'b1; b = '0; n = 0;
    while (tx !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    if (tx !== 1'b0) begin ok = 1'b0; return; end
    for (int k = 1; k < CLK_DIV; k++) begin @(negedge clk); if (tx !== 1'b0) ok = 1'b0; end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); b[i] = tx;
      for (int k = 1; k < CLK_DIV; k++) begin @(negedge clk); if (tx !== b[i]) ok = 1'b0; end
    end
    for (int k = 0; k < CLK_DIV; k++) begin @(negedge clk); if (tx !== 1'b1) ok = 1'b0; end
    @(negedge clk);
  endtask

  task automatic capture_frame(input int n);
    logic [7:0] b;
    bit ok;
    for (int i = 0; i < n; i++) begin
      capture_byte(b, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL uart_framing byte %0d: timeout or malformed bit, got %02h", i, b);
        break;
      end
      if (b !== exp_q[i]) begin
        errors++;
        $display("FAIL frame_byte %0d: got %02h expected %02h", i, b, exp_q[i]);
      end
      last_rx = b;
      rx_count++;
    end
  endtask

  task automatic start_frame(input logic [31:0] pc, input logic [31:0] ad, input logic [31:0] in);
    dbg_pc = pc; dbg_addr = ad; dbg_inst = in;
    build_exp(pc, ad, in);
    @(negedge clk);
    done_cnt = 0; busy_cnt = 0; rx_count = 0; addr_log.delete();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_latency: tx=%b busy=%b expected tx=0 busy=1", tx, busy);
    end
  endtask

  // Called at the FIN cycle, right after the last stop bit.
  task automatic end_frame_checks();
    bit seq_ok;
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL done_timing: done=%b expected 1", done);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      errors++; $display("FAIL done_pulse: busy=%b done_cycles=%0d expected 0 and 1", busy, done_cnt);
    end
    checks++;
    if (busy_cnt < BUSY_EXP - 2 || busy_cnt > BUSY_EXP + 2) begin
      errors++; $display("FAIL busy_time: got %0d expected %0d", busy_cnt, BUSY_EXP);
    end
    seq_ok = (addr_log.size() == NR);
    if (seq_ok)
      for (int i = 0; i < NR; i++)
        if (addr_log[i] !== 5'((i + 1) % NR)) seq_ok = 1'b0;
    checks++;
    if (!seq_ok) begin
      errors++; $display("FAIL reg_addr_seq: %0d changes seen, expected 1..%0d then 0", addr_log.size(), NR - 1);
    end
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || debug_reg_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: tx=%b busy=%b done=%b addr=%0d", tx, busy, done, debug_reg_addr);
    end
    aresetn = 1'b1;
    begin
      int lows = 0;
      for (int i = 0; i < 100; i++) begin @(negedge clk); if (tx !== 1'b1 || busy !== 1'b0) lows++; end
      checks++;
      if (lows != 0) begin errors++; $display("FAIL idle_line: %0d non-idle cycles, expected 0", lows); end
    end
  endtask

  task automatic test_fixed_frame();
    rand_mode = 1'b0;
    start_frame(32'h0000_0010, 32'h0000_0004, 32'h0050_0093);
    capture_frame(NB);
    end_frame_checks();
  endtask

  task automatic test_retrigger();
    logic [31:0] pc;
    rand_mode = 1'b1;
    foreach (regfile[i]) regfile[i] = $urandom;
    pc = $urandom;
    start_frame(pc, $urandom, $urandom);
    fork
      capture_frame(NB);
      begin
        int n = 0;
        while (rx_count < 20 && n < 20000) begin @(negedge clk); n++; end
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        dbg_pc = ~pc;
      end
    join
    // Trigger aligned with FIN must also be dropped.
    trigger = 1'b1;
    end_frame_checks_fin();
    begin
      int lows = 0;
      for (int i = 0; i < 200; i++) begin @(negedge clk); if (tx !== 1'b1 || busy !== 1'b0) lows++; end
      checks++;
      if (lows != 0) begin errors++; $display("FAIL dropped_trigger: %0d busy/low cycles, expected 0", lows); end
    end
  endtask

  task automatic end_frame_checks_fin();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL done_timing_fin: done=%b expected 1", done); end
    @(negedge clk);
    trigger = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done_cnt != 1) begin
      errors++; $display("FAIL fin_trigger: busy=%b done_cycles=%0d expected 0 and 1", busy, done_cnt);
    end
  endtask

  task automatic test_reset_mid_byte();
    int n;
    rand_mode = 1'b1;
    foreach (regfile[i]) regfile[i] = $urandom;
    start_frame($urandom, $urandom, $urandom);
    capture_frame(49);
    n = 0;
    while (tx !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    repeat (CLK_DIV + 6) @(negedge clk);
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || debug_reg_addr !== 5'd0) begin
      errors++;
      $display("FAIL async_reset_mid: tx=%b busy=%b addr=%0d expected 1 0 0", tx, busy, debug_reg_addr);
    end
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    repeat (5) @(negedge clk);
    foreach (regfile[i]) regfile[i] = $urandom;
    start_frame($urandom, $urandom, $urandom);
    capture_frame(NB);
    end_frame_checks();
  endtask

`ifdef DEBUG_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    rand_mode = 1'b1;
    foreach (regfile[i]) regfile[i] = '0;
    start_frame(32'h0, 32'h0, 32'h0);
    capture_frame(NB);
    checks++;
    if (last_rx !== 8'h00) begin errors++; $display("FAIL checksum_zero: got %02h expected 00", last_rx); end
    end_frame_checks();
    start_frame(32'h0000_00FF, 32'h0, 32'h0);
    capture_frame(NB);
    checks++;
    if (last_rx !== 8'hFF) begin errors++; $display("FAIL checksum_ff: got %02h expected ff", last_rx); end
    end_frame_checks();
  endtask
`endif

  initial begin
    test_reset();
    test_fixed_frame();
    test_retrigger();
    test_reset_mid_byte();
`ifdef DEBUG_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
